// File: rtl/cache_ctrl_param_if.sv
// Bundle between the cache controller, the pipeline memory stage, one cache
// array per way and the fixed-latency main memory.
// slave: the controller. master: everything around it (pipeline, arrays, memory).
interface cache_ctrl_param_if #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 3,
    parameter int unsigned WAYS     = 2
) ();
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    // Pipeline request/response
    logic [ADDR_W-1:0]      Addr;
    logic [DATA_W-1:0]      DataIn;
    logic                   Rd;
    logic                   Wr;
    logic [DATA_W-1:0]      DataOut;
    logic                   Done;
    logic                   Stall;
    logic                   CacheHit;
    logic                   Err;
    // Cache arrays, way w in slice w of each bus
    logic [WAYS-1:0]        cache_enable;
    logic                   cache_comp;
    logic                   cache_write;
    logic                   cache_valid_in;
    logic [TAG_W-1:0]       cache_tag_in;
    logic [INDEX_W-1:0]     cache_index;
    logic [OFFSET_W-1:0]    cache_offset;
    logic [DATA_W-1:0]      cache_data_in;
    logic [WAYS-1:0]        cache_hit;
    logic [WAYS-1:0]        cache_valid;
    logic [WAYS-1:0]        cache_dirty;
    logic [WAYS*TAG_W-1:0]  cache_tag_out;
    logic [WAYS*DATA_W-1:0] cache_data_out;
    // Main memory
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data_in;
    logic                   mem_wr;
    logic                   mem_rd;
    logic [DATA_W-1:0]      mem_data_out;

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, CacheHit, Err,
        output cache_enable, cache_comp, cache_write, cache_valid_in,
        output cache_tag_in, cache_index, cache_offset, cache_data_in,
        input  cache_hit, cache_valid, cache_dirty, cache_tag_out, cache_data_out,
        output mem_addr, mem_data_in, mem_wr, mem_rd,
        input  mem_data_out
    );

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, CacheHit, Err,
        input  cache_enable, cache_comp, cache_write, cache_valid_in,
        input  cache_tag_in, cache_index, cache_offset, cache_data_in,
        output cache_hit, cache_valid, cache_dirty, cache_tag_out, cache_data_out,
        input  mem_addr, mem_data_in, mem_wr, mem_rd,
        output mem_data_out
    );
endinterface

// File: rtl/cache_ctrl_param.sv
// Data-cache controller: 1/2-way, per-set LRU, configurable line size and
// memory latency, with write-back of dirty victims and a latched request.
module cache_ctrl_param #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 3,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned MEM_LAT  = 2
) (
    input logic               clk,
    input logic               rst,
    cache_ctrl_param_if.slave bus
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LW    = 2 ** (OFFSET_W - 1);
    localparam int unsigned SETS  = 2 ** INDEX_W;
    localparam logic [OFFSET_W-1:0] LastWord  = OFFSET_W'(LW - 1);
    localparam logic [OFFSET_W-1:0] AllIssued = OFFSET_W'(LW);

    typedef enum logic [2:0] {StIdle, StCompare, StWb, StFill, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   d_q, d_d, dout_q, dout_d;
    logic                wr_q, wr_d, err_q, err_d, first_q, first_d, hit_q, hit_d;
    logic                vic_q, vic_d;
    logic [TAG_W-1:0]    vtag_q, vtag_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d, ret_q, ret_d;
    logic [MEM_LAT-1:0]  pend_q, pend_d;
    logic [SETS-1:0]     lru_q, lru_d;

    logic [TAG_W-1:0]    a_tag;
    logic [INDEX_W-1:0]  a_idx;
    logic [OFFSET_W-1:0] a_off, cnt_off, ret_off;
    logic [WAYS-1:0]     hit_vec, vic_oh;
    logic                hit_any, hit_way, victim, issue;

    assign a_tag   = a_q[ADDR_W-1 -: TAG_W];
    assign a_idx   = a_q[OFFSET_W +: INDEX_W];
    assign a_off   = a_q[OFFSET_W-1:0];
    assign cnt_off = OFFSET_W'({cnt_q, 1'b0});
    assign ret_off = OFFSET_W'({ret_q, 1'b0});
    assign hit_vec = bus.cache_hit & bus.cache_valid;
    assign hit_any = |hit_vec;
    assign hit_way = (WAYS > 1) ? hit_vec[WAYS-1] : 1'b0;

    assign bus.Done     = (state_q == StDone);
    assign bus.Stall    = (state_q != StIdle);
    assign bus.Err      = (state_q == StDone) & err_q;
    assign bus.CacheHit = hit_q;
    assign bus.DataOut  = dout_q;

    // Victim choice: first invalid way, else the set's LRU way.
    always_comb begin
        if (!bus.cache_valid[0]) begin
            victim = 1'b0;
        end else if (WAYS > 1 && !bus.cache_valid[WAYS-1]) begin
            victim = 1'b1;
        end else begin
            victim = (WAYS > 1) ? lru_q[a_idx] : 1'b0;
        end
        vic_oh         = '0;
        vic_oh[vic_q]  = 1'b1;
    end

    // Next-state, latch updates and cache/memory drive.
    always_comb begin
        state_d = state_q;  a_d = a_q;  d_d = d_q;  dout_d = dout_q;
        wr_d = wr_q;  err_d = err_q;  first_d = first_q;  hit_d = hit_q;
        vic_d = vic_q;  vtag_d = vtag_q;  cnt_d = cnt_q;  ret_d = ret_q;  lru_d = lru_q;
        issue = 1'b0;
        bus.cache_enable = '0;  bus.cache_comp = 1'b0;  bus.cache_write = 1'b0;
        bus.cache_valid_in = 1'b0;  bus.cache_tag_in = '0;  bus.cache_index = '0;
        bus.cache_offset = '0;  bus.cache_data_in = '0;
        bus.mem_addr = '0;  bus.mem_data_in = '0;  bus.mem_wr = 1'b0;  bus.mem_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Rd || bus.Wr) begin
                    a_d     = bus.Addr;
                    d_d     = bus.DataIn;
                    wr_d    = bus.Wr;
                    err_d   = bus.Rd & bus.Wr;
                    first_d = 1'b1;
                    hit_d   = 1'b0;
                    state_d = (bus.Rd && bus.Wr) ? StDone : StCompare;
                end
            end
            StCompare: begin
                bus.cache_enable   = '1;
                bus.cache_comp     = 1'b1;
                bus.cache_write    = wr_q;
                bus.cache_valid_in = wr_q;
                bus.cache_data_in  = d_q;
                bus.cache_tag_in   = a_tag;
                bus.cache_index    = a_idx;
                bus.cache_offset   = a_off;
                first_d            = 1'b0;
                // A write that came back from a fill must not report a hit.
                if (first_q) hit_d = hit_any;
                if (hit_any) begin
                    dout_d = bus.cache_data_out[32'(hit_way)*DATA_W +: DATA_W];
                    if (WAYS > 1) lru_d[a_idx] = ~hit_way;
                    state_d = StDone;
                end else begin
                    vic_d   = victim;
                    vtag_d  = bus.cache_tag_out[32'(victim)*TAG_W +: TAG_W];
                    cnt_d   = '0;
                    ret_d   = '0;
                    state_d = (bus.cache_valid[victim] && bus.cache_dirty[victim]) ? StWb
                                                                                   : StFill;
                end
            end
            StWb: begin
                bus.cache_enable = vic_oh;
                bus.cache_index  = a_idx;
                bus.cache_offset = cnt_off;
                bus.mem_wr       = 1'b1;
                bus.mem_addr     = {vtag_q, a_idx, cnt_off};
                bus.mem_data_in  = bus.cache_data_out[32'(vic_q)*DATA_W +: DATA_W];
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == LastWord) begin
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (cnt_q != AllIssued) begin
                    issue        = 1'b1;
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = {a_tag, a_idx, cnt_off};
                    cnt_d        = cnt_q + 1'b1;
                end
                // Oldest outstanding read returns this cycle.
                if (pend_q[MEM_LAT-1]) begin
                    bus.cache_enable   = vic_oh;
                    bus.cache_write    = 1'b1;
                    bus.cache_valid_in = 1'b1;
                    bus.cache_tag_in   = a_tag;
                    bus.cache_index    = a_idx;
                    bus.cache_offset   = ret_off;
                    bus.cache_data_in  = bus.mem_data_out;
                    if (!wr_q && ret_off == a_off) dout_d = bus.mem_data_out;
                    ret_d = ret_q + 1'b1;
                    if (ret_q == LastWord) begin
                        state_d = wr_q ? StCompare : StDone;
                        if (!wr_q && WAYS > 1) lru_d[a_idx] = ~vic_q;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read-return delay line: bit i set means a read issued i+1 cycles ago.
    always_comb begin
        pend_d[0] = issue;
        for (int i = 1; i < int'(MEM_LAT); i++) pend_d[i] = pend_q[i-1];
    end

    // State and latch registers; reset drops any line in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;  a_q <= '0;  d_q <= '0;  dout_q <= '0;
            wr_q <= 1'b0;  err_q <= 1'b0;  first_q <= 1'b0;  hit_q <= 1'b0;
            vic_q <= 1'b0;  vtag_q <= '0;  cnt_q <= '0;  ret_q <= '0;
            pend_q <= '0;  lru_q <= '0;
        end else begin
            state_q <= state_d;  a_q <= a_d;  d_q <= d_d;  dout_q <= dout_d;
            wr_q <= wr_d;  err_q <= err_d;  first_q <= first_d;  hit_q <= hit_d;
            vic_q <= vic_d;  vtag_q <= vtag_d;  cnt_q <= cnt_d;  ret_q <= ret_d;
            pend_q <= pend_d;  lru_q <= lru_d;
        end
    end
endmodule

// File: tb/tb_cache_ctrl_param.sv
// Directed bench for cache_ctrl_param with behavioural cache arrays and a
// two-cycle-latency main memory.
module tb_cache_ctrl_param;
    logic clk = 1'b0;
    logic rst;

    cache_ctrl_param_if bus ();
    cache_ctrl_param dut (.clk(clk), .rst(rst), .bus(bus));

    // 10 ns clock
    always #5 clk = ~clk;

    // Cache arrays: 2 ways x 256 sets x 4 words, 5-bit tags.
    logic [15:0] c_data [2][256][4];
    logic [4:0]  c_tag  [2][256];
    logic        c_val  [2][256] = '{default: 1'b0};
    logic        c_dirty[2][256] = '{default: 1'b0};

    // Array read side
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            bus.cache_hit[w]               = (c_tag[w][bus.cache_index] == bus.cache_tag_in);
            bus.cache_valid[w]             = c_val[w][bus.cache_index];
            bus.cache_dirty[w]             = c_dirty[w][bus.cache_index];
            bus.cache_tag_out[w*5 +: 5]    = c_tag[w][bus.cache_index];
            bus.cache_data_out[w*16 +: 16] = c_data[w][bus.cache_index][bus.cache_offset[2:1]];
        end
    end

    // Array write side
    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (bus.cache_enable[w] && bus.cache_write) begin
                if (!bus.cache_comp) begin
                    c_data[w][bus.cache_index][bus.cache_offset[2:1]] <= bus.cache_data_in;
                    c_tag[w][bus.cache_index]   <= bus.cache_tag_in;
                    c_val[w][bus.cache_index]   <= bus.cache_valid_in;
                    c_dirty[w][bus.cache_index] <= 1'b0;
                end else if (c_val[w][bus.cache_index] &&
                             c_tag[w][bus.cache_index] == bus.cache_tag_in) begin
                    c_data[w][bus.cache_index][bus.cache_offset[2:1]] <= bus.cache_data_in;
                    c_dirty[w][bus.cache_index] <= 1'b1;
                end
            end
        end
    end

    // Memory word w initially holds w + 0x1000; mem_x stores the XOR delta.
    logic [15:0] mem_x [32768] = '{default: 16'h0};
    logic [14:0] rd_p0 = '0;
    logic [14:0] rd_p1 = '0;

    function automatic logic [15:0] mem_init(input logic [14:0] w);
        return {1'b0, w} + 16'h1000;
    endfunction

    // Memory write port and two-stage read address pipe
    always @(posedge clk) begin
        if (bus.mem_wr) mem_x[bus.mem_addr[15:1]] <= bus.mem_data_in ^ mem_init(bus.mem_addr[15:1]);
        rd_p0 <= bus.mem_addr[15:1];
        rd_p1 <= rd_p0;
    end
    assign bus.mem_data_out = mem_x[rd_p1] ^ mem_init(rd_p1);

    // Traffic monitor
    int n_rd = 0, n_cw = 0, n_both = 0;
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    always @(posedge clk) begin
        if (bus.mem_wr) begin
            wr_addr_log.push_back(bus.mem_addr);
            wr_data_log.push_back(bus.mem_data_in);
        end
        if (bus.mem_rd) n_rd++;
        if (bus.cache_write && |bus.cache_enable) n_cw++;
        if (bus.mem_rd && bus.mem_wr) n_both++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request at a posedge+1 point; returns the Done cycle (-1 on timeout).
    task automatic run_req(input logic [15:0] a, input logic [15:0] d, input logic r,
                           input logic w, output int dc, output logic h,
                           output logic [15:0] dq, output logic e);
        dc = -1; h = 1'b0; dq = 16'h0; e = 1'b0;
        bus.Addr = a; bus.DataIn = d; bus.Rd = r; bus.Wr = w;
        @(posedge clk); #1;
        bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = ~a; bus.DataIn = ~d;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.Done) begin
                dc = c; h = bus.CacheHit; dq = bus.DataOut; e = bus.Err;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Hard stop if something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    int dc, rd0, cw0, wb0;
    logic h, e;
    logic [15:0] dq;

    // Directed sequence
    initial begin
        rst = 1'b0; bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {bus.Stall, bus.Done, bus.Err, bus.CacheHit, bus.mem_rd, bus.mem_wr,
                           bus.cache_write, bus.cache_comp, bus.cache_valid_in,
                           bus.cache_enable}, 32'h0);
        check("rst_dout", bus.DataOut, 32'h0);
        check("rst_maddr", bus.mem_addr, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("idle_stall", bus.Stall, 32'h0);

        // Cold read miss: way 0 of set 2
        run_req(16'h0010, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("rd1_cyc", dc, 8); check("rd1_hit", h, 0);
        check("rd1_data", dq, 16'h1008); check("rd1_err", e, 0);

        // Write hit then read hit
        run_req(16'h0012, 16'hBEEF, 1'b0, 1'b1, dc, h, dq, e);
        check("wr_hit_cyc", dc, 2); check("wr_hit_hit", h, 1);
        run_req(16'h0012, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("rd_hit_cyc", dc, 2); check("rd_hit_hit", h, 1); check("rd_hit_data", dq, 16'hBEEF);

        // Clean write miss into way 1 of set 2
        wb0 = wr_addr_log.size(); rd0 = n_rd;
        run_req(16'h0814, 16'h1234, 1'b0, 1'b1, dc, h, dq, e);
        check("wr_miss_cyc", dc, 9); check("wr_miss_hit", h, 0);
        check("wr_miss_nowb", wr_addr_log.size() - wb0, 0);
        check("wr_miss_rds", n_rd - rd0, 4);

        // Third tag in set 2: evict dirty LRU way 0 (tag 0)
        wb0 = wr_addr_log.size();
        run_req(16'h1010, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("ev1_cyc", dc, 12); check("ev1_hit", h, 0); check("ev1_data", dq, 16'h1808);
        check("ev1_nwb", wr_addr_log.size() - wb0, 4);
        for (int k = 0; k < 4; k++) check("ev1_wb_addr", wr_addr_log[wb0+k], 16'h0010 + 2*k);
        check("ev1_wb_d1", wr_data_log[wb0+1], 16'hBEEF);
        check("ev1_wb_d2", wr_data_log[wb0+2], 16'h100A);

        // Old line comes back from memory; evicts dirty way 1 (tag 1)
        wb0 = wr_addr_log.size();
        run_req(16'h0012, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("ev2_cyc", dc, 12); check("ev2_data", dq, 16'hBEEF);
        check("ev2_wb_a0", wr_addr_log[wb0], 16'h0810);
        check("ev2_wb_d2", wr_data_log[wb0+2], 16'h1234);

        // LRU in set 5: A, B, A, C -> B evicted, A kept
        run_req(16'h1828, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("lru_a_cyc", dc, 8); check("lru_a_data", dq, 16'h1C14);
        run_req(16'h2028, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("lru_b_cyc", dc, 8); check("lru_b_data", dq, 16'h2014);
        run_req(16'h1828, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("lru_a2_cyc", dc, 2); check("lru_a2_hit", h, 1);
        wb0 = wr_addr_log.size();
        run_req(16'h2828, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("lru_c_cyc", dc, 8); check("lru_c_data", dq, 16'h2414);
        check("lru_c_nowb", wr_addr_log.size() - wb0, 0);
        run_req(16'h1828, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("lru_a3_hit", h, 1); check("lru_a3_data", dq, 16'h1C14);
        run_req(16'h2028, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("lru_b2_hit", h, 0); check("lru_b2_cyc", dc, 8);

        // Illegal Rd & Wr
        wb0 = wr_addr_log.size(); rd0 = n_rd; cw0 = n_cw;
        run_req(16'h0040, 16'h5555, 1'b1, 1'b1, dc, h, dq, e);
        check("ill_cyc", dc, 1); check("ill_err", e, 1);
        check("ill_rd", n_rd - rd0, 0); check("ill_wr", wr_addr_log.size() - wb0, 0);
        check("ill_cw", n_cw - cw0, 0);

        // Reset during the third FILL cycle (cycle 4)
        bus.Addr = 16'h3030; bus.Rd = 1'b1;
        @(posedge clk); #1;
        bus.Rd = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mf_pre_rd", bus.mem_rd, 1);
        cw0 = n_cw;
        #2 rst = 1'b0;
        #1;
        check("mf_rd", bus.mem_rd, 0); check("mf_stall", bus.Stall, 0);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mf_no_cw", n_cw - cw0, 0);
        check("mf_idle", bus.Stall, 0);
        run_req(16'h3030, 16'h0, 1'b1, 1'b0, dc, h, dq, e);
        check("mf_after_cyc", dc, 8); check("mf_after_data", dq, 16'h2818);
        check("mf_after_err", e, 0);

        check("rd_wr_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_ctrl_param.md
# cache_ctrl_param

Parametrised controller for the data-memory cache of the processor. It sits between the pipeline memory stage and the `four_bank`-style fixed-latency main memory, and drives one cache array instance per way. It generalises the single-way, 4-word-line controller in three ways:
- configurable line size, index width and memory latency;
- 1- or 2-way set associativity with per-set LRU replacement;
- a request address/data latch, so `Addr` and `DataIn` may change after acceptance.

## Interface
Parameters:
- `ADDR_W`, default 16: byte-address width.
- `DATA_W`, default 16: word width; one word is 2 bytes.
- `INDEX_W`, default 8: set-index bits.
- `OFFSET_W`, default 3: byte-offset bits. `LW = 2^(OFFSET_W-1)` words per line.
- `WAYS`, default 2: legal values are 1 or 2.
- `MEM_LAT`, default 2: cycles from `mem_rd` issue to valid `mem_data_out`.
- `TAG_W` is derived: `ADDR_W-INDEX_W-OFFSET_W`.

Ports:
- `clk` in, 1: the single clock.
- `rst` in, 1: asynchronous, active-low reset.
- `Addr` in, ADDR_W: request address.
- `DataIn` in, DATA_W: request write data.
- `Rd` in, 1: read request.
- `Wr` in, 1: write request.
- `DataOut` out, DATA_W: read data, valid while `Done`=1.
- `Done` out, 1: one-cycle completion pulse.
- `Stall` out, 1: high whenever the controller is not in IDLE.
- `CacheHit` out, 1: valid with `Done`.
- `Err` out, 1: pulses with `Done` when `Rd`&`Wr` are both high.
- Cache array outputs: `cache_enable` out [WAYS-1:0]; `cache_comp`, `cache_write`, `cache_valid_in` out, 1 each; `cache_tag_in` out, TAG_W; `cache_index` out, INDEX_W; `cache_offset` out, OFFSET_W; `cache_data_in` out, DATA_W.
- Cache array inputs: `cache_hit`, `cache_valid`, `cache_dirty` in [WAYS-1:0]; `cache_tag_out` in, WAYS*TAG_W; `cache_data_out` in, WAYS*DATA_W. Way w occupies slice w of each bus.
- Memory: `mem_addr` out, ADDR_W; `mem_data_in` out, DATA_W; `mem_wr` out, 1; `mem_rd` out, 1; `mem_data_out` in, DATA_W.

## Operation
- States: IDLE, COMPARE, WB (write-back), FILL, DONE.
- **IDLE.** `Rd|Wr` is accepted in IDLE only. On acceptance the controller latches `Addr`, `DataIn` and the op into A, D and OP, and goes to COMPARE.
  - If `Rd`&`Wr`: go directly to DONE with `Err`=1 and no cache or memory access.
- **COMPARE.**
  - Drives all ways with `cache_enable`=all-ones, `cache_comp`=1, `cache_write`=(OP==write), `cache_data_in`=D, and tag/index/offset from A.
  - Hit means `cache_hit[w]&cache_valid[w]` for some way w. On a hit: capture way w's data, update LRU[index] to the other way, go to DONE.
  - The hit flag is latched on the first COMPARE of a request only.
- **Victim selection** on a miss:
  - the first invalid way, way 0 preferred;
  - otherwise way LRU[index];
  - `WAYS`=1 always selects way 0.
  - If the victim is valid and dirty, go to WB; otherwise go to FILL.
- **WB.** LW cycles, word k=0..LW-1.
  - Victim way enabled with `cache_comp`=0, `cache_write`=0, `cache_offset`=2k.
  - `mem_wr`=1, `mem_addr`={victim tag, index, 2k}, `mem_data_in`=victim data.
  - Then go to FILL.
- **FILL.**
  - Issue `mem_rd` with `mem_addr`={A tag, index, 2k} on LW consecutive cycles.
  - Return counter: word k arrives MEM_LAT cycles after its issue. On that cycle, write the victim way with `cache_write`=1, `cache_comp`=0, `cache_valid_in`=1, tag from A, offset 2k, data `mem_data_out`.
  - On a read, if 2k==A offset, capture `mem_data_out` into the DataOut register.
  - After the last return:
    - write op: return to COMPARE, which now hits and marks the line dirty; `CacheHit` stays 0;
    - read op: go to DONE and set LRU[index] to the other way.
- **DONE.** Assert `Done` for one cycle, then go to IDLE.
- **Reset.** `rst`=0 forces IDLE immediately and clears every LRU bit, the counters and all latches.
  - All outputs are 0, including `Stall`, `Done`, `mem_rd`, `mem_wr` and `cache_enable`.
  - Reset in the middle of WB or FILL abandons the line, with no further memory or cache writes. Cache contents are left undefined.
- Memory returns arriving after a reset are ignored.

## Timing
- Cycle 0 is the IDLE cycle that samples the request.
- `Stall`=1 from cycle 1 until and including the `Done` cycle.
- `DataOut` and `CacheHit` are registered and stable during `Done`; `DataOut` holds its value after `Done`.
- Read or write hit: `Done` at cycle 2.
- Clean read miss: `Done` at cycle 2+LW+MEM_LAT, which is 8 with the defaults.
- Clean write miss: one cycle later than a clean read miss.
- Dirty miss: add LW cycles to the clean-miss figure.
- Memory issue and return may overlap; `mem_rd` and `mem_wr` are never high in the same cycle.

## Test plan
- **Reset.** Hold `rst`=0 then release → all outputs 0, `Stall`=0. First read of 0x0010 misses, with `Done` at cycle 8 and `CacheHit`=0.
- **Read hit.** Write 0xBEEF to 0x0012, then read 0x0012 → `Done` at cycle 2, `CacheHit`=1, `DataOut`=0xBEEF.
- **Dirty eviction** (`WAYS`=2). Dirty both ways of index 2, then read a third tag → four `mem_wr` to the LRU way's old line at offsets 0, 2, 4, 6 in order, followed by the fill. `Done` at cycle 12.
- **LRU.** Read tags A and B, re-read A, then miss on C → tag B is evicted and A still hits.
- **Illegal request.** `Rd`=`Wr`=1 → `Err`=1 and `Done` at cycle 1, with no `mem_rd`, `mem_wr` or `cache_write`.
- **Reset mid-fill.** Assert reset during the third FILL cycle → same cycle `mem_rd`=0 and `Stall`=0; the next request is accepted normally.
